// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper: walks {A,B,C,D} through all 16 codes, cross-checks the
// three realisations of f,g,h and captures each canonical truth table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        f,
    input  logic        fPOS,
    input  logic        fSOP,
    input  logic        g,
    input  logic        gPOS,
    input  logic        gSOP,
    input  logic        h,
    input  logic        hPOS,
    input  logic        hSOP,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx,
    output logic [2:0]  err_func,
    output logic [15:0] f_tt,
    output logic [15:0] g_tt,
    output logic [15:0] h_tt
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  abcd_q, abcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  errc_q, errc_d;
    logic [3:0]  first_q, first_d;
    logic [2:0]  efunc_q, efunc_d;
    logic [15:0] ftt_q, ftt_d;
    logic [15:0] gtt_q, gtt_d;
    logic [15:0] htt_q, htt_d;
    logic [2:0]  mism;

    // A realisation disagrees when the three copies are not all equal.
    assign mism = {(h != hPOS) || (h != hSOP),
                   (g != gPOS) || (g != gSOP),
                   (f != fPOS) || (f != fSOP)};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        abcd_d  = abcd_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        first_d = first_q;
        efunc_d = efunc_q;
        ftt_d   = ftt_q;
        gtt_d   = gtt_q;
        htt_d   = htt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                abcd_d = 4'd0;
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = 4'd0;
                    errc_d  = 5'd0;
                    first_d = 4'd0;
                    efunc_d = 3'd0;
                    ftt_d   = 16'd0;
                    gtt_d   = 16'd0;
                    htt_d   = 16'd0;
                end
            end
            S_LOAD: begin
                abcd_d  = idx_q;
                cnt_d   = SETTLE_CNT;
                state_d = (SETTLE_CNT == 4'd0) ? S_SAMPLE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                ftt_d[idx_q] = f;
                gtt_d[idx_q] = g;
                htt_d[idx_q] = h;
                if (|mism) begin
                    errc_d  = errc_q + 5'd1;
                    efunc_d = efunc_q | mism;
                    if (errc_q == 5'd0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                    abcd_d  = 4'd0;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                abcd_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            abcd_q  <= 4'd0;
            cnt_q   <= 4'd0;
            errc_q  <= 5'd0;
            first_q <= 4'd0;
            efunc_q <= 3'd0;
            ftt_q   <= 16'd0;
            gtt_q   <= 16'd0;
            htt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abcd_q  <= abcd_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
            first_q <= first_d;
            efunc_q <= efunc_d;
            ftt_q   <= ftt_d;
            gtt_q   <= gtt_d;
            htt_q   <= htt_d;
        end
    end

    assign {A, B, C, D}  = abcd_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (errc_q == 5'd0);
    assign err_count     = errc_q;
    assign first_err_idx = first_q;
    assign err_func      = efunc_q;
    assign f_tt          = ftt_q;
    assign g_tt          = gtt_q;
    assign h_tt          = htt_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a behavioural eje6 stand-in with selectable faults feeds the
// sweeper (SETTLE=1) and a second SETTLE=0 instance.
`default_nettype none

module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start0 = 1'b0;
    int   mode = 0;
    int   errors = 0;
    int   checks = 0;

    logic A, B, C, D;
    logic f, fPOS, fSOP, g, gPOS, gSOP, h, hPOS, hSOP;
    logic busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic [2:0]  err_func;
    logic [15:0] f_tt, g_tt, h_tt;

    logic A0, B0, C0, D0;
    logic busy0, done0, pass0;
    logic [4:0]  err_count0;
    logic [3:0]  first_err_idx0;
    logic [2:0]  err_func0;
    logic [15:0] f_tt0, g_tt0, h_tt0;

    always #5 clk = ~clk;

    // eje6 stand-in: f = A^B, g = D, h = 0, with optional planted faults.
    always_comb begin
        f    = A ^ B;
        fPOS = A ^ B;
        fSOP = A ^ B;
        g    = D;
        gPOS = D;
        gSOP = D;
        h    = 1'b0;
        hPOS = 1'b0;
        hSOP = 1'b0;
        if (mode == 1 && {A, B, C, D} == 4'd5) fSOP = ~(A ^ B);
        if (mode == 2) gPOS = 1'b0;
    end

    truth_table_sweeper #(.SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .C(C), .D(D),
        .f(f), .fPOS(fPOS), .fSOP(fSOP),
        .g(g), .gPOS(gPOS), .gSOP(gSOP),
        .h(h), .hPOS(hPOS), .hSOP(hSOP),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .err_func(err_func),
        .f_tt(f_tt), .g_tt(g_tt), .h_tt(h_tt)
    );

    truth_table_sweeper #(.SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .A(A0), .B(B0), .C(C0), .D(D0),
        .f(A0 ^ B0), .fPOS(A0 ^ B0), .fSOP(A0 ^ B0),
        .g(D0), .gPOS(D0), .gSOP(D0),
        .h(1'b0), .hPOS(1'b0), .hSOP(1'b0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err_count0), .first_err_idx(first_err_idx0), .err_func(err_func0),
        .f_tt(f_tt0), .g_tt(g_tt0), .h_tt(h_tt0)
    );

    // Pulse start for one cycle, then count posedges until busy drops.
    task automatic run_sweep(output int n, output logic [3:0] v4, output logic [3:0] v46);
        n = 0;
        v4 = 4'hx;
        v46 = 4'hx;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 4)  v4  = {A, B, C, D};
            if (n == 46) v46 = {A, B, C, D};
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, A, B, C, D} !== 7'd0 || err_count !== 5'd0 || first_err_idx !== 4'd0 ||
            err_func !== 3'd0 || f_tt !== 16'd0 || g_tt !== 16'd0 || h_tt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b abcd=%b%b%b%b ec=%0d fe=%0d ef=%b tt=%h/%h/%h required all zero",
                     busy, done, pass, A, B, C, D, err_count, first_err_idx, err_func, f_tt, g_tt, h_tt);
        end
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || f_tt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_state_settle0: busy=%b done=%b f_tt=%h required 0 0 0000", busy0, done0, f_tt0);
        end
        reset = 1'b0;
    endtask

    task automatic check_case1(input string tag);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 5'd0 || err_func !== 3'd0 || first_err_idx !== 4'd0) begin
            errors++;
            $display("FAIL %s_status: done=%b pass=%b ec=%0d ef=%b fe=%0d required 1 1 0 000 0",
                     tag, done, pass, err_count, err_func, first_err_idx);
        end
        checks++;
        if (f_tt !== 16'h0FF0 || g_tt !== 16'hAAAA || h_tt !== 16'h0000) begin
            errors++;
            $display("FAIL %s_tt: f=%h g=%h h=%h required 0ff0 aaaa 0000", tag, f_tt, g_tt, h_tt);
        end
    endtask

    task automatic test_consistent;
        int n;
        logic [3:0] v4, v46;
        mode = 0;
        run_sweep(n, v4, v46);
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL consistent_busy_cycles: got %0d required 48", n);
        end
        checks++;
        if (v4 !== 4'd1 || v46 !== 4'd15 || {A, B, C, D} !== 4'd0) begin
            errors++;
            $display("FAIL consistent_stimulus: abcd@4=%0d abcd@46=%0d abcd@done=%0d required 1 15 0",
                     v4, v46, {A, B, C, D});
        end
        check_case1("consistent");
    endtask

    task automatic test_single_fault;
        int n;
        logic [3:0] v4, v46;
        mode = 1;
        run_sweep(n, v4, v46);
        checks++;
        if (err_count !== 5'd1 || first_err_idx !== 4'd5 || err_func !== 3'b001 || pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL single_fault: ec=%0d fe=%0d ef=%b pass=%b done=%b required 1 5 001 0 1",
                     err_count, first_err_idx, err_func, pass, done);
        end
        mode = 0;
    endtask

    task automatic test_stuck_gpos;
        int n;
        logic [3:0] v4, v46;
        mode = 2;
        run_sweep(n, v4, v46);
        checks++;
        if (err_count !== 5'd8 || first_err_idx !== 4'd1 || err_func !== 3'b010 || g_tt !== 16'hAAAA || pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck_gpos: ec=%0d fe=%0d ef=%b g_tt=%h pass=%b required 8 1 010 aaaa 0",
                     err_count, first_err_idx, err_func, g_tt, pass);
        end
        mode = 0;
    endtask

    task automatic test_mid_reset;
        int n;
        logic [3:0] v4, v46;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || {A, B, C, D} !== 4'd0 || err_count !== 5'd0 || f_tt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b abcd=%0d ec=%0d f_tt=%h required 0 0 0 0000",
                     busy, {A, B, C, D}, err_count, f_tt);
        end
        run_sweep(n, v4, v46);
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL mid_reset_resweep_cycles: got %0d required 48", n);
        end
        check_case1("mid_reset_resweep");
    endtask

    task automatic test_start_ignored;
        int n;
        n = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = (n == 10);
        end
        start = 1'b0;
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL start_ignored_cycles: got %0d required 48", n);
        end
        check_case1("start_ignored");
        // restart from DONE
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || f_tt !== 16'd0) begin
            errors++;
            $display("FAIL restart_from_done: done=%b busy=%b f_tt=%h required 0 1 0000", done, busy, f_tt);
        end
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL restart_cycles: got %0d required 48", n);
        end
        check_case1("restart");
    endtask

    task automatic test_settle0;
        int n;
        n = 0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        while (busy0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL settle0_cycles: got %0d required 32", n);
        end
        checks++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || err_count0 !== 5'd0 || err_func0 !== 3'd0 ||
            f_tt0 !== 16'h0FF0 || g_tt0 !== 16'hAAAA || h_tt0 !== 16'h0000 || {A0, B0, C0, D0} !== 4'd0) begin
            errors++;
            $display("FAIL settle0_result: done=%b pass=%b ec=%0d ef=%b tt=%h/%h/%h required 1 1 0 000 0ff0/aaaa/0000",
                     done0, pass0, err_count0, err_func0, f_tt0, g_tt0, h_tt0);
        end
    endtask

    initial begin
        test_reset();
        test_consistent();
        test_single_fault();
        test_stuck_gpos();
        test_mid_reset();
        test_start_ignored();
        test_settle0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
